// File: rtl/factor_checker_n.sv
// Order-insensitive answer checker for the factorization game: compares a submitted
// factor set against the loaded problem, tracks remaining attempts and drives LED status.
module factor_checker_n #(
  parameter int W         = 8,
  parameter int N         = 3,
  parameter int MAX_TRIES = 3,
  parameter int TRY_W     = $clog2(MAX_TRIES + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             new_problem,
  input  logic [N*W-1:0]   num_array,
  input  logic             submit,
  input  logic [N*W-1:0]   check_in,
  output logic [1:0]       result,
  output logic [TRY_W-1:0] tries_left,
  output logic             busy,
  output logic             done
);

  localparam int               IDX_W      = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N - 1);
  localparam logic [TRY_W-1:0] TRIES_INIT = TRY_W'(MAX_TRIES);
  localparam logic [TRY_W-1:0] TRIES_ONE  = TRY_W'(1);
  localparam logic [TRY_W-1:0] TRIES_ZERO = {TRY_W{1'b0}};
  localparam logic [N*W-1:0]   VEC_ZERO   = {(N*W){1'b0}};
  localparam logic [1:0]       RES_NONE   = 2'b00;
  localparam logic [1:0]       RES_OK     = 2'b01;
  localparam logic [1:0]       RES_LOCK   = 2'b10;
  localparam logic [1:0]       RES_RETRY  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_COMPARE = 2'b01,
    S_RESULT  = 2'b10
  } state_t;

  state_t             state_r;
  logic [N*W-1:0]     exp_r;
  logic [N*W-1:0]     ans_r;
  logic [N-1:0]       used_r;
  logic [IDX_W-1:0]   idx_r;
  logic               mismatch_r;
  logic               solved_r;
  logic [1:0]         result_r;
  logic [TRY_W-1:0]   tries_r;
  logic               busy_r;
  logic               done_r;

  logic [W-1:0]       cur_factor_s;
  logic [N-1:0]       used_next_s;
  logic               hit_s;
  logic               accept_s;

  assign result     = result_r;
  assign tries_left = tries_r;
  assign busy       = busy_r;
  assign done       = done_r;

  assign accept_s = submit && (check_in != VEC_ZERO) && (tries_r != TRIES_ZERO) && !solved_r;

  // Select the answer factor addressed by the compare index.
  always_comb begin
    cur_factor_s = {W{1'b0}};
    for (int k = 0; k < N; k++) begin
      if (idx_r == IDX_W'(k)) begin
        cur_factor_s = ans_r[k*W +: W];
      end else begin
        cur_factor_s = cur_factor_s;
      end
    end
  end

  // Claim the lowest unused expected slot holding the current factor.
  always_comb begin
    used_next_s = used_r;
    hit_s       = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!hit_s && !used_r[j] && (exp_r[j*W +: W] == cur_factor_s)) begin
        used_next_s[j] = 1'b1;
        hit_s          = 1'b1;
      end else begin
        used_next_s[j] = used_r[j];
      end
    end
  end

  // Control FSM with registered status outputs; a new problem aborts any comparison.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= S_IDLE;
      exp_r      <= VEC_ZERO;
      ans_r      <= VEC_ZERO;
      used_r     <= {N{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
      mismatch_r <= 1'b0;
      solved_r   <= 1'b0;
      result_r   <= RES_NONE;
      tries_r    <= TRIES_INIT;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else if (new_problem) begin
      state_r  <= S_IDLE;
      exp_r    <= num_array;
      solved_r <= 1'b0;
      result_r <= RES_NONE;
      tries_r  <= TRIES_INIT;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            ans_r      <= check_in;
            used_r     <= {N{1'b0}};
            idx_r      <= {IDX_W{1'b0}};
            mismatch_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          used_r <= used_next_s;
          if (!hit_s) begin
            mismatch_r <= 1'b1;
          end
          idx_r <= idx_r + IDX_W'(1);
          if (idx_r == IDX_LAST) begin
            state_r <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (!mismatch_r) begin
            result_r <= RES_OK;
            solved_r <= 1'b1;
          end else if (tries_r == TRIES_ONE) begin
            result_r <= RES_LOCK;
            tries_r  <= TRIES_ZERO;
          end else begin
            result_r <= RES_RETRY;
            tries_r  <= tries_r - TRIES_ONE;
          end
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= S_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
